// File: rtl/arm_uc_pkg.sv
// arm_uc_pkg: shared widths, microstore entry points and field encodings for the ARMSIM microsequencer
package arm_uc_pkg;
    localparam int SW = 7;
    localparam logic [SW-1:0] FETCH_ST = 7'd1;
    localparam logic [SW-1:0] ABORT_ST = 7'd127;
    localparam int MOC_TMO = 16;
    typedef enum logic [2:0] {
        NS_ENCODE = 3'd0,
        NS_INC    = 3'd1,
        NS_JUMP   = 3'd2,
        NS_CBR    = 3'd3,
        NS_CWAIT  = 3'd4,
        NS_CALL   = 3'd5,
        NS_RET    = 3'd6,
        NS_FETCH  = 3'd7
    } nSel_e;
    typedef enum logic [1:0] {
        CS_MOC  = 2'd0,
        CS_COND = 2'd1,
        CS_ALUZ = 2'd2,
        CS_ONE  = 2'd3
    } csSel_e;
endpackage

// File: rtl/usq_cond_sel.sv
// usq_cond_sel: picks the branch/wait condition source and applies the optional inversion
module usq_cond_sel
    import arm_uc_pkg::*;
(
    input  logic [1:0] cs_sel,
    input  logic       inv,
    input  logic       moc,
    input  logic       cond_pass,
    input  logic       alu_z,
    output logic       c
);
    // 4:1 condition mux followed by the invert bit
    always_comb
        c = ((cs_sel == CS_MOC)  ? moc :
             (cs_sel == CS_COND) ? cond_pass :
             (cs_sel == CS_ALUZ) ? alu_z : 1'b1) ^ inv;
endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: registered microstore address generator with branch, memory wait/timeout and one-level call
module micro_sequencer #(
    parameter int SW = arm_uc_pkg::SW,
    parameter logic [SW-1:0] FETCH_ST = arm_uc_pkg::FETCH_ST,
    parameter logic [SW-1:0] ABORT_ST = arm_uc_pkg::ABORT_ST,
    parameter int MOC_TMO = arm_uc_pkg::MOC_TMO
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [SW-1:0] enc_state,
    input  logic [SW-1:0] cr_addr,
    input  logic [2:0]    n_sel,
    input  logic [1:0]    cs_sel,
    input  logic          inv,
    input  logic          moc,
    input  logic          cond_pass,
    input  logic          alu_z,
    output logic [SW-1:0] state,
    output logic          mem_fault,
    output logic          ret_valid
);
    import arm_uc_pkg::*;

    localparam int CW = $clog2(MOC_TMO + 1);

    logic          c;
    logic [SW-1:0] inc;
    logic [SW-1:0] retReg;
    logic [CW-1:0] waitCnt;

    usq_cond_sel condSel (
        .cs_sel(cs_sel),
        .inv(inv),
        .moc(moc),
        .cond_pass(cond_pass),
        .alu_z(alu_z),
        .c(c)
    );

    assign inc = state + SW'(1);

    // Next-state selection; unknown select codes fall through and leave every register untouched
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= '0;
            retReg    <= '0;
            ret_valid <= 1'b0;
            waitCnt   <= '0;
            mem_fault <= 1'b0;
        end else begin
            case (n_sel)
                NS_ENCODE: begin
                    state     <= enc_state;
                    waitCnt   <= '0;
                    mem_fault <= 1'b0;
                end
                NS_INC: begin
                    state     <= inc;
                    waitCnt   <= '0;
                    mem_fault <= 1'b0;
                end
                NS_JUMP: begin
                    state     <= cr_addr;
                    waitCnt   <= '0;
                    mem_fault <= 1'b0;
                end
                NS_CBR: begin
                    state     <= c ? cr_addr : inc;
                    waitCnt   <= '0;
                    mem_fault <= 1'b0;
                end
                NS_CWAIT: begin
                    if (c) begin
                        state     <= inc;
                        waitCnt   <= '0;
                        mem_fault <= 1'b0;
                    end else if (waitCnt == CW'(MOC_TMO - 1)) begin
                        state     <= ABORT_ST;
                        waitCnt   <= '0;
                        mem_fault <= 1'b1;
                    end else begin
                        waitCnt   <= waitCnt + CW'(1);
                        mem_fault <= 1'b0;
                    end
                end
                NS_CALL: begin
                    retReg    <= inc;
                    ret_valid <= 1'b1;
                    state     <= cr_addr;
                    waitCnt   <= '0;
                    mem_fault <= 1'b0;
                end
                NS_RET: begin
                    state     <= ret_valid ? retReg : FETCH_ST;
                    ret_valid <= 1'b0;
                    waitCnt   <= '0;
                    mem_fault <= 1'b0;
                end
                NS_FETCH: begin
                    state     <= FETCH_ST;
                    waitCnt   <= '0;
                    mem_fault <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed vector table plus hand sequences for wait timeout and reset corners
module tb_micro_sequencer;
    typedef struct {
        logic       rst;
        logic [6:0] enc;
        logic [6:0] cr;
        logic [2:0] ns;
        logic [1:0] cs;
        logic       inv;
        logic       moc;
        logic       cp;
        logic       az;
        logic [6:0] expState;
        logic       expFault;
        logic       expRv;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] encState;
    logic [6:0] crAddr;
    logic [2:0] nSel;
    logic [1:0] csSel;
    logic       inv;
    logic       moc;
    logic       condPass;
    logic       aluZ;
    logic [6:0] state;
    logic       memFault;
    logic       retValid;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    micro_sequencer dut (
        .clk(clk),
        .reset(reset),
        .enc_state(encState),
        .cr_addr(crAddr),
        .n_sel(nSel),
        .cs_sel(csSel),
        .inv(inv),
        .moc(moc),
        .cond_pass(condPass),
        .alu_z(aluZ),
        .state(state),
        .mem_fault(memFault),
        .ret_valid(retValid)
    );

    function automatic vec_t mk(input logic r, input logic [6:0] e, input logic [6:0] a, input logic [2:0] n,
                                input logic [1:0] s, input logic i, input logic m, input logic p, input logic z,
                                input logic [6:0] es, input logic ef, input logic ev);
        vec_t v;
        v.rst = r; v.enc = e; v.cr = a; v.ns = n; v.cs = s; v.inv = i; v.moc = m; v.cp = p; v.az = z;
        v.expState = es; v.expFault = ef; v.expRv = ev;
        return v;
    endfunction

    task automatic step(input vec_t v, input string name);
        reset = v.rst; encState = v.enc; crAddr = v.cr; nSel = v.ns; csSel = v.cs;
        inv = v.inv; moc = v.moc; condPass = v.cp; aluZ = v.az;
        @(posedge clk);
        #1;
        checks += 3;
        if (state !== v.expState) begin
            errors++;
            $display("FAIL %s state: got %0d expected %0d", name, state, v.expState);
        end
        if (memFault !== v.expFault) begin
            errors++;
            $display("FAIL %s mem_fault: got %b expected %b", name, memFault, v.expFault);
        end
        if (retValid !== v.expRv) begin
            errors++;
            $display("FAIL %s ret_valid: got %b expected %b", name, retValid, v.expRv);
        end
    endtask

    initial begin
        vec_t tbl[27];
        tbl[0]  = mk(1, 0, 0, 3'd1, 0, 0, 0, 0, 0,   0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 3'd1, 0, 0, 0, 0, 0,   0, 0, 0);
        tbl[2]  = mk(0, 4, 0, 3'd0, 0, 0, 0, 0, 0,   4, 0, 0);
        tbl[3]  = mk(0, 0, 5, 3'd2, 0, 0, 0, 0, 0,   5, 0, 0);
        tbl[4]  = mk(0, 0, 0, 3'd1, 0, 0, 0, 0, 0,   6, 0, 0);
        tbl[5]  = mk(0, 0, 0, 3'd1, 0, 0, 0, 0, 0,   7, 0, 0);
        tbl[6]  = mk(0, 0, 0, 3'd1, 0, 0, 0, 0, 0,   8, 0, 0);
        tbl[7]  = mk(0, 0, 127, 3'd2, 0, 0, 0, 0, 0, 127, 0, 0);
        tbl[8]  = mk(0, 0, 0, 3'd1, 0, 0, 0, 0, 0,   0, 0, 0);
        tbl[9]  = mk(0, 0, 40, 3'd3, 2, 0, 0, 0, 1,  40, 0, 0);
        tbl[10] = mk(0, 0, 40, 3'd3, 2, 1, 0, 0, 1,  41, 0, 0);
        tbl[11] = mk(0, 0, 90, 3'd3, 1, 0, 0, 0, 0,  42, 0, 0);
        tbl[12] = mk(0, 0, 90, 3'd3, 3, 0, 0, 0, 0,  90, 0, 0);
        tbl[13] = mk(0, 0, 90, 3'd3, 3, 1, 0, 0, 0,  91, 0, 0);
        tbl[14] = mk(0, 0, 0, 3'd4, 0, 0, 0, 0, 0,  91, 0, 0);
        tbl[15] = mk(0, 0, 0, 3'd4, 0, 0, 0, 0, 0,  91, 0, 0);
        tbl[16] = mk(0, 0, 0, 3'd4, 0, 0, 0, 0, 0,  91, 0, 0);
        tbl[17] = mk(0, 0, 0, 3'd4, 0, 0, 1, 0, 0,  92, 0, 0);
        tbl[18] = mk(0, 0, 20, 3'd2, 0, 0, 0, 0, 0,  20, 0, 0);
        tbl[19] = mk(0, 0, 60, 3'd5, 0, 0, 0, 0, 0,  60, 0, 1);
        tbl[20] = mk(0, 0, 0, 3'd6, 0, 0, 0, 0, 0,  21, 0, 0);
        tbl[21] = mk(0, 0, 0, 3'd6, 0, 0, 0, 0, 0,   1, 0, 0);
        tbl[22] = mk(0, 0, 127, 3'd2, 0, 0, 0, 0, 0, 127, 0, 0);
        tbl[23] = mk(0, 0, 3, 3'd5, 0, 0, 0, 0, 0,   3, 0, 1);
        tbl[24] = mk(0, 0, 10, 3'd5, 0, 0, 0, 0, 0,  10, 0, 1);
        tbl[25] = mk(0, 0, 0, 3'd6, 0, 0, 0, 0, 0,   4, 0, 0);
        tbl[26] = mk(0, 0, 0, 3'd7, 0, 0, 0, 0, 0,   1, 0, 0);
        for (int i = 0; i < 27; i++) step(tbl[i], $sformatf("vec%0d", i));

        step(mk(0, 0, 50, 3'd2, 0, 0, 0, 0, 0, 50, 0, 0), "tmo_jump");
        for (int i = 0; i < 15; i++) step(mk(0, 0, 0, 3'd4, 0, 0, 0, 0, 0, 50, 0, 0), $sformatf("tmo_hold%0d", i));
        step(mk(0, 0, 0, 3'd4, 0, 0, 0, 0, 0, 127, 1, 0), "tmo_abort");
        step(mk(0, 0, 0, 3'd1, 0, 0, 0, 0, 0, 0, 0, 0), "tmo_pulse_end");

        step(mk(0, 0, 50, 3'd2, 0, 0, 0, 0, 0, 50, 0, 0), "late_jump");
        for (int i = 0; i < 15; i++) step(mk(0, 0, 0, 3'd4, 0, 0, 0, 0, 0, 50, 0, 0), $sformatf("late_hold%0d", i));
        step(mk(0, 0, 0, 3'd4, 0, 0, 1, 0, 0, 51, 0, 0), "late_moc");
        step(mk(0, 0, 0, 3'd1, 0, 0, 0, 0, 0, 52, 0, 0), "late_nofault");

        step(mk(0, 0, 50, 3'd5, 0, 0, 0, 0, 0, 50, 0, 1), "rst_call");
        for (int i = 0; i < 10; i++) step(mk(0, 0, 0, 3'd4, 0, 0, 0, 0, 0, 50, 0, 1), $sformatf("rst_hold%0d", i));
        step(mk(1, 0, 0, 3'd4, 0, 0, 0, 0, 0, 0, 0, 0), "rst_mid_wait");
        for (int i = 0; i < 15; i++) step(mk(0, 0, 0, 3'd4, 0, 0, 0, 0, 0, 0, 0, 0), $sformatf("post_rst_hold%0d", i));
        step(mk(0, 0, 0, 3'd4, 0, 0, 0, 0, 0, 127, 1, 0), "post_rst_abort");
        step(mk(0, 0, 0, 3'd6, 0, 0, 0, 0, 0, 1, 0, 0), "post_rst_ret");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
